// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam logic [3:0] ROW_RESET = 4'b1110;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } res_kind_t;

  function automatic logic [2:0] hit_count(input logic [3:0] hits);
    hit_count = {2'b00, hits[0]} + {2'b00, hits[1]} + {2'b00, hits[2]} + {2'b00, hits[3]};
  endfunction

  // Column index of the lowest active hit; only meaningful when one bit is set.
  function automatic logic [1:0] first_col(input logic [3:0] hits);
    if (hits[0]) begin
      first_col = 2'd0;
    end else if (hits[1]) begin
      first_col = 2'd1;
    end else if (hits[2]) begin
      first_col = 2'd2;
    end else begin
      first_col = 2'd3;
    end
  endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// Row scan timing: dwell counter, active row index, registered row drive and
// the per-dwell sample / per-frame end strobes.
module keypad_scan_timer
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_n,
  output logic [1:0] row_idx,
  output logic       sample_en,
  output logic       frame_end
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] dwell_r;
  logic [1:0]    row_idx_r;
  logic [3:0]    row_n_r;
  logic [1:0]    row_nxt_s;

  assign row_nxt_s = row_idx_r + 2'd1;
  assign sample_en = (dwell_r == CW'(SCAN_DIV - 1));
  assign frame_end = sample_en && (row_idx_r == 2'd3);
  assign row_n     = row_n_r;
  assign row_idx   = row_idx_r;

  // Dwell counter and row advance at the last cycle of each dwell.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_r   <= {CW{1'b0}};
      row_idx_r <= 2'd0;
      row_n_r   <= ROW_RESET;
    end else if (sample_en) begin
      dwell_r   <= {CW{1'b0}};
      row_idx_r <= row_nxt_s;
      row_n_r   <= ~(4'b0001 << row_nxt_s);
    end else begin
      dwell_r   <= dwell_r + CW'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: synchronizes columns, classifies each frame, debounces
// and emits committed key codes. Define KEYPAD_REPEAT_EN for auto-repeat strobes.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_FRAMES  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_FRAMES < 1) begin : g_param_check
    $error("keypad_scanner: parameter out of range");
  end

  logic [3:0]  col_meta_r, col_sync_r;
  logic [1:0]  row_idx_s;
  logic        sample_en_s, frame_end_s;
  logic [3:0]  hits_s;
  logic [2:0]  sum_s;
  logic [3:0]  frame_code_s;
  logic [1:0]  acc_cnt_r;
  logic [3:0]  acc_code_r;
  res_kind_t   res_kind_s, prev_kind_r;
  logic [3:0]  res_code_s, prev_code_r;
  logic [SW-1:0] stab_r, stab_nxt_s;
  logic        stable_s;
  state_t      state_r, state_nxt_s;
  logic [3:0]  key_code_r, code_nxt_s;
  logic        key_valid_r, valid_nxt_s, key_held_r;

  keypad_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .row_idx   (row_idx_s),
    .sample_en (sample_en_s),
    .frame_end (frame_end_s)
  );

  // Two-flop synchronizer for the asynchronous column lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_r <= 4'hF;
      col_sync_r <= 4'hF;
    end else begin
      col_meta_r <= col_n;
      col_sync_r <= col_meta_r;
    end
  end

  // Frame result includes the row being sampled on the frame-end cycle.
  assign hits_s       = ~col_sync_r;
  assign sum_s        = {1'b0, acc_cnt_r} + hit_count(hits_s);
  assign frame_code_s = (acc_cnt_r == 2'd1) ? acc_code_r : {row_idx_s, first_col(hits_s)};
  assign res_kind_s   = (sum_s == 3'd0) ? RES_NONE : ((sum_s == 3'd1) ? RES_SINGLE : RES_MULTI);
  assign res_code_s   = (res_kind_s == RES_SINGLE) ? frame_code_s : 4'h0;

  assign stab_nxt_s = ((res_kind_s == prev_kind_r) && (res_code_s == prev_code_r)) ?
                      ((stab_r == SW'(DEBOUNCE_SCANS)) ? stab_r : stab_r + SW'(1)) : SW'(1);
  assign stable_s   = (stab_nxt_s == SW'(DEBOUNCE_SCANS));

  // Per-frame hit accumulation (saturates at 2) and stability tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt_r   <= 2'd0;
      acc_code_r  <= 4'h0;
      prev_kind_r <= RES_NONE;
      prev_code_r <= 4'h0;
      stab_r      <= {SW{1'b0}};
    end else if (frame_end_s) begin
      acc_cnt_r   <= 2'd0;
      prev_kind_r <= res_kind_s;
      prev_code_r <= res_code_s;
      stab_r      <= stab_nxt_s;
    end else if (sample_en_s) begin
      acc_cnt_r   <= (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
      acc_code_r  <= frame_code_s;
    end else begin
      acc_cnt_r   <= acc_cnt_r;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  logic [RW-1:0] rep_cnt_r, rep_nxt_s;
`endif

  // Press/release decisions happen only at frame end; ghosting ignored while pressed.
  always_comb begin
    state_nxt_s = state_r;
    code_nxt_s  = key_code_r;
    valid_nxt_s = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_nxt_s   = rep_cnt_r;
`endif
    case (state_r)
      IDLE: begin
`ifdef KEYPAD_REPEAT_EN
        rep_nxt_s = {RW{1'b0}};
`endif
        if (frame_end_s && stable_s && (res_kind_s == RES_SINGLE)) begin
          state_nxt_s = PRESSED;
          code_nxt_s  = res_code_s;
          valid_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PRESSED: begin
        if (frame_end_s && stable_s && (res_kind_s == RES_NONE)) begin
          state_nxt_s = IDLE;
`ifdef KEYPAD_REPEAT_EN
          rep_nxt_s   = {RW{1'b0}};
        end else if (frame_end_s) begin
          if (rep_cnt_r == RW'(REPEAT_FRAMES - 1)) begin
            valid_nxt_s = 1'b1;
            rep_nxt_s   = {RW{1'b0}};
          end else begin
            rep_nxt_s   = rep_cnt_r + RW'(1);
          end
`endif
        end else begin
          state_nxt_s = PRESSED;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      key_code_r  <= 4'h0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_r   <= {RW{1'b0}};
`endif
    end else begin
      state_r     <= state_nxt_s;
      key_code_r  <= code_nxt_s;
      key_valid_r <= valid_nxt_s;
      key_held_r  <= (state_nxt_s == PRESSED);
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_r   <= rep_nxt_s;
`endif
    end
  end

  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;

endmodule
